// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and default sizing for the two-port register file arbiter.
package reg_file_arbiter_pkg;
    typedef enum logic {INIT, RUN} state_t;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 2;
    localparam int INIT_VAL_DEF = 0;
endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; grants only while advance is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr;  // 0 favours requester 0 on contention

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    // After serving one side, hand priority to the other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr <= 1'b0;
        else if (|gnt)   ptr <= gnt[0];
    end
endmodule

// File: rtl/reg_file_arbiter.sv
// Clears an external register file after reset, then arbitrates two
// requesters onto its single write port and single read port.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int            DW       = DW_DEF,
    parameter int            AW       = AW_DEF,
    parameter logic [DW-1:0] INIT_VAL = DW'(INIT_VAL_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          init_done,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_w_addr,
    output logic [DW-1:0] rf_w_data,
    output logic [AW-1:0] rf_r_addr,
    input  logic [DW-1:0] rf_r_data
);
    localparam logic [AW-1:0] LAST = '1;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic [1:0]    gnt;
    logic          run;
    logic          rd0, rd1;

    assign run       = (state == RUN);
    assign init_done = run;
    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1, req0}),
        .advance (run),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) cnt <= cnt + 1'b1;
        end
    end

    // rst gates the port outright: state already reads INIT during reset,
    // which would otherwise drive a clear write.
    always_comb begin
        state_nxt = state;
        rf_wr_en  = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        rf_r_addr = '0;
        rd0       = 1'b0;
        rd1       = 1'b0;
        if (!rst) begin
            if (state == INIT) begin
                rf_wr_en  = 1'b1;
                rf_w_addr = cnt;
                rf_w_data = INIT_VAL;
                if (cnt == LAST) state_nxt = RUN;
            end else if (gnt[0]) begin
                if (we0) begin
                    rf_wr_en  = 1'b1;
                    rf_w_addr = addr0;
                    rf_w_data = wdata0;
                end else begin
                    rf_r_addr = addr0;
                    rd0       = 1'b1;
                end
            end else if (gnt[1]) begin
                if (we1) begin
                    rf_wr_en  = 1'b1;
                    rf_w_addr = addr1;
                    rf_w_data = wdata1;
                end else begin
                    rf_r_addr = addr1;
                    rd1       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            if (rd0) rdata0 <= rf_r_data;
            if (rd1) rdata1 <= rf_r_data;
        end
    end
endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameter DW, 8, data width of the shared register file.
REQ-002 Parameter AW, 2, register file address width (2**AW entries).
REQ-003 Parameter INIT_VAL, 0, value written to every entry after reset.
REQ-004 Port list SHALL be: clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 req0/req1  in  1  access request from requester 0/1, held until granted.
REQ-007 we0/we1  in  1  1 = write, 0 = read.
REQ-008 addr0/addr1  in  AW  target entry.
REQ-009 wdata0/wdata1  in  DW  write data.
REQ-010 gnt0/gnt1  out  1  same-cycle grant; the request is consumed at the next rising edge.
REQ-011 rvalid0/rvalid1  out  1  one-cycle pulse; rdata valid.
REQ-012 rdata0/rdata1  out  DW  registered read data.
REQ-013 init_done  out  1  high once the clear sequence is complete.
REQ-014 rf_wr_en, rf_w_addr(AW), rf_w_data(DW), rf_r_addr(AW)  out  drive the register file.
REQ-015 rf_r_data  in  DW  combinational register file read data.

Function
REQ-016 FSM states: INIT, RUN; INIT entered on reset.
REQ-017 INIT: counter steps 0..2**AW-1, one entry per cycle, rf_wr_en=1, rf_w_addr=counter, rf_w_data=INIT_VAL; no grants are issued.
REQ-018 After the last entry is written, go to RUN; init_done rises in the first RUN cycle (2**AW cycles after reset release) and stays high.
REQ-019 RUN: at most one grant per cycle; gnt is combinational from req, pointer state and FSM state.
REQ-020 Only one requester asserts req: it is granted in that cycle.
REQ-021 Both requesters assert req: grant goes to the requester indicated by a round-robin pointer.
REQ-022 Pointer: reset value selects requester 0; after any grant to requester i, it selects the other requester; no grant leaves it unchanged.
REQ-023 Granted write: rf_wr_en=1, rf_w_addr=addr, rf_w_data=wdata in the grant cycle; the entry updates at that edge.
REQ-024 Granted read: rf_r_addr=addr in the grant cycle; rf_r_data is registered into rdata of the granted requester at that edge; its rvalid is high for exactly the next cycle.
REQ-025 Read latency is 1 cycle from grant; back-to-back reads from the same requester yield rvalid on consecutive cycles.
REQ-026 A read granted in the cycle after a write to the same address returns the new data.
REQ-027 No grant: rf_wr_en=0, rf_r_addr=0; rdata holds its last value.
REQ-028 req deasserted without a grant: the request is dropped and has no side effects.

Reset
REQ-029 rst high: state=INIT, counter=0, pointer=0, gnt*=0, rvalid*=0, rdata*=0, init_done=0, rf_wr_en forced 0.
REQ-030 Reset asserted mid-INIT or mid-RUN aborts all activity immediately; a pending rvalid is cancelled; the full clear sequence reruns after release.

Structure
REQ-031 Package reg_file_arbiter_pkg SHALL hold the state enum (INIT, RUN) and the default DW/AW/INIT_VAL constants.
REQ-032 The round-robin pointer and grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]).

Verification
REQ-033 Reset release, no requests -> rf_wr_en high for 4 cycles at addresses 0,1,2,3 with data 0; init_done rises in cycle 5.
REQ-034 After init: req0 write addr 2 data 110; next cycle req1 read addr 2 -> gnt1, rvalid1 one cycle later, rdata1=110.
REQ-035 req0 and req1 both held with writes (100 to addr0, 101 to addr1) -> grants alternate 0,1; both entries correct on readback.
REQ-036 Reads requested during INIT -> no gnt until init_done; first read of any entry returns 0.
REQ-037 rst asserted the cycle after a granted read -> rvalid never pulses; INIT reruns and clears previously written data (readback 0).
REQ-038 req1 alone, 3 consecutive reads of addr 3 (value 120) -> 3 consecutive rvalid1 pulses, each with rdata1=120.
